game_autoplayer: RTL
====================

GAME_AUTOPLAYER -- requirements
Module: game_autoplayer

Interface
REQ-001 Parameter: MAX_STEPS, default 12, maximum decision cycles before giving up (range 1..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces all state and outputs to reset values.
REQ-004 start  input  1  one-cycle request to begin playing; sampled only in IDLE.
REQ-005 room  input  7  game room indication {s6..s0}, one-hot: [0] Cave, [1] Tunnel, [2] River, [3] Stash, [4] Den, [5] Vault, [6] Graveyard.
REQ-006 win  input  1  game win flag.
REQ-007 d  input  1  game death flag.
REQ-008 n, s, e, w  output  1 each  registered direction pulses driven to the game's n/s/e/w inputs.
REQ-009 busy  output  1  high in ISSUE and GAP.
REQ-010 done  output  1  high while in DONE (game won).
REQ-011 fail  output  1  high while in FAIL.
REQ-012 steps  output  4  count of decision cycles taken since start.

Function
REQ-013 States: IDLE, ISSUE, GAP, DONE, FAIL; all outputs registered or decoded from state only.
REQ-014 IDLE: start=1 -> ISSUE, steps cleared to 0, sword flag cleared; otherwise remain.
REQ-015 ISSUE evaluates in strict priority, one decision per cycle:
  - d=1 or room[6]=1 -> FAIL;
  - win=1 or room[5]=1 -> DONE;
  - room not exactly one-hot -> FAIL;
  - steps==MAX_STEPS -> FAIL;
  - otherwise apply route table, steps+1, -> GAP.
REQ-016 Route table: Cave -> e; Tunnel -> s; River with sword flag 0 -> w; River with sword flag 1 -> e; Stash -> e and set sword flag; Den -> no pulse (game advances itself).
REQ-017 Sword flag set on the ISSUE decision that observes room[3]; cleared only by reset or start.
REQ-018 The selected direction output is high for exactly the one cycle following the ISSUE decision (i.e. during GAP); at most one of n/s/e/w high at any time; all low in every other state.
REQ-019 GAP: unconditionally -> ISSUE next cycle (gives the game one edge to sample the pulse and update room).
REQ-020 steps saturates at 15; never wraps.
REQ-021 DONE and FAIL are sticky; exit only via start=1 (-> ISSUE, restarting as in REQ-014) or reset.
REQ-022 start while busy=1 is ignored; no effect on state, steps, or pulses.
REQ-023 Simultaneous win and d in one ISSUE cycle -> FAIL (death has priority).

Reset
REQ-024 On reset assertion, immediately (no clock needed): state IDLE, n=s=e=w=0, busy=0, done=0, fail=0, steps=0, sword flag=0.
REQ-025 Reset mid-play aborts any pending pulse in the same instant; no pulse is issued until a new start after reset deasserts.

Verification
REQ-026 Reset, start pulse with a behavioural game model starting in Cave -> pulse sequence e, s, w, e, e (each one cycle, separated by one idle cycle), Den decision with no pulse, then done=1, fail=0, steps=6.
REQ-027 Model forces d=1 while autoplayer is in River with sword flag 0 -> next ISSUE enters FAIL; fail=1, done=0, no further pulses.
REQ-028 room held at Cave, never changing, MAX_STEPS=12 -> exactly 12 e pulses, then fail=1 with steps=12.
REQ-029 room=7'b0000011 presented at an ISSUE -> FAIL with no pulse; room=0 likewise -> FAIL.
REQ-030 start asserted during GAP -> ignored; then reset asserted during GAP with e high -> e, busy, steps go to 0 immediately; IDLE held until next start.
REQ-031 win=1 and d=1 together at an ISSUE -> fail=1, done=0; start from FAIL -> ISSUE with steps=0 and a fresh route.

Source files
------------

// File: rtl/game_autoplayer.sv
// Autoplayer for the cave adventure: reads the room, issues one direction pulse per
// decision, and stops on win, death, malformed room or exhausted step budget.
module game_autoplayer #(
    parameter int unsigned MAX_STEPS = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] room,
    input  logic       win,
    input  logic       d,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] steps
);

    typedef enum logic [2:0] {IDLE, ISSUE, GAP, DONE, FAIL} state_t;

    localparam logic [3:0] STEP_LIMIT = 4'(MAX_STEPS);

    state_t state;
    logic   sword;
    logic   room_valid;

    assign room_valid = $onehot(room);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n     <= 1'b0;
            s     <= 1'b0;
            e     <= 1'b0;
            w     <= 1'b0;
            steps <= '0;
            sword <= 1'b0;
        end else begin
            // Direction pulses live for exactly one cycle: only an ISSUE->GAP move raises one.
            n <= 1'b0;
            s <= 1'b0;
            e <= 1'b0;
            w <= 1'b0;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state <= ISSUE;
                        steps <= '0;
                        sword <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (d || room[6]) begin
                        state <= FAIL;
                    end else if (win || room[5]) begin
                        state <= DONE;
                    end else if (!room_valid) begin
                        state <= FAIL;
                    end else if (steps == STEP_LIMIT) begin
                        state <= FAIL;
                    end else begin
                        state <= GAP;
                        if (steps != 4'hf) begin
                            steps <= steps + 4'd1;
                        end
                        if (room[0]) begin
                            e <= 1'b1;
                        end else if (room[1]) begin
                            s <= 1'b1;
                        end else if (room[2]) begin
                            if (sword) e <= 1'b1;
                            else       w <= 1'b1;
                        end else if (room[3]) begin
                            e     <= 1'b1;
                            sword <= 1'b1;
                        end
                        // Den: no pulse, the game moves on by itself.
                    end
                end
                GAP: begin
                    state <= ISSUE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state == ISSUE) || (state == GAP);
        done = (state == DONE);
        fail = (state == FAIL);
    end

endmodule
